// File: rtl/bb_uart_rx.sv
// 8N1 UART receiver running on the system clock with internal bit timing.
// Holds the last byte with a ready flag and reports framing and overrun errors.
module bb_uart_rx #(
    parameter int unsigned CLK_DIVIDER  = 521,
    parameter int unsigned HALF_DIVIDER = CLK_DIVIDER / 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rxd,
    input  logic       rxack,
    output logic [7:0] rxreg,
    output logic       rxrdy,
    output logic       rxbsy,
    output logic       frmerr,
    output logic       ovrerr
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIVIDER - 1);
    // Compared before the increment so the start check lands HALF_DIVIDER edges after entry
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIVIDER - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s2_d;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       rxreg_nxt;
    logic             rxrdy_nxt, frmerr_nxt, ovrerr_nxt;

    // Two-flop synchronizer plus edge history for falling-edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s2_d <= 1'b1;
        end else begin
            s1   <= rxd;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            rxreg  <= '0;
            rxrdy  <= 1'b0;
            rxbsy  <= 1'b0;
            frmerr <= 1'b0;
            ovrerr <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shreg  <= shreg_nxt;
            rxreg  <= rxreg_nxt;
            rxrdy  <= rxrdy_nxt;
            rxbsy  <= (state_nxt != IDLE);
            frmerr <= frmerr_nxt;
            ovrerr <= ovrerr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shreg_nxt  = shreg;
        rxreg_nxt  = rxreg;
        rxrdy_nxt  = rxrdy;
        ovrerr_nxt = ovrerr;
        frmerr_nxt = 1'b0;

        // Acknowledge clears; a coinciding good stop re-sets rxrdy below
        if (rxack) begin
            rxrdy_nxt  = 1'b0;
            ovrerr_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!s2 && s2_d) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {s2, shreg[7:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (!s2) begin
                        frmerr_nxt = 1'b1;
                    end else if (!rxrdy || rxack) begin
                        rxreg_nxt = shreg;
                        rxrdy_nxt = 1'b1;
                    end else begin
                        ovrerr_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
